// File: rtl/timer_counter_bcd_if.sv
// Control inputs and BCD display outputs of the min:sec countdown counter.
// master drives the controls (control FSM side), slave is the counter itself.
interface timer_counter_bcd_if;
  logic       enable_counter;
  logic       forward;
  logic       reset_timer;
  logic       seg_demand;
  logic       min_demand;
  logic [3:0] sec_units;
  logic [3:0] sec_tens;
  logic [3:0] min_units;
  logic [3:0] min_tens;
  logic       zero;
  logic       done;

  modport master (
    output enable_counter, forward, reset_timer, seg_demand, min_demand,
    input  sec_units, sec_tens, min_units, min_tens, zero, done
  );

  modport slave (
    input  enable_counter, forward, reset_timer, seg_demand, min_demand,
    output sec_units, sec_tens, min_units, min_tens, zero, done
  );
endinterface

// File: rtl/timer_counter_bcd.sv
// Min:sec BCD countdown counter: set mode accumulates time, count mode steps down once per second.
// Optional feature macro: TIMER_AUTOREPEAT_EN (held set requests auto-repeat every REPEAT_CYCLES).
module timer_counter_bcd #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int REPEAT_CYCLES = 12_500_000
) (
  input logic              clk,
  input logic              reset,
  timer_counter_bcd_if.slave bus
);
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  if (TICKS_PER_SEC < 2 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("timer_counter_bcd: TICKS_PER_SEC must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic [3:0]    r_su, r_st, r_mu, r_mt;
  logic [PW-1:0] r_presc;
  logic          r_seg_q, r_min_q, r_zero, r_done;

  logic [3:0]    w_su, w_st, w_mu, w_mt;
  logic [PW-1:0] w_presc;
  logic          w_set, w_cnt, w_tick, w_at_one, w_done, w_zero;
  logic          w_seg_inc, w_min_inc, w_rep_seg, w_rep_min;

  assign w_set    = bus.enable_counter & bus.forward;
  assign w_cnt    = bus.enable_counter & ~bus.forward;
  assign w_tick   = w_cnt && (r_presc == PRESC_LAST);
  assign w_at_one = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd1);

`ifdef TIMER_AUTOREPEAT_EN
  localparam int RCW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);
  logic [RCW-1:0] r_rep_seg, r_rep_min;
  logic           w_hold_seg, w_hold_min;

  // A request counts as held once the edge register has already seen it high.
  assign w_hold_seg = w_set & bus.seg_demand & r_seg_q;
  assign w_hold_min = w_set & bus.min_demand & r_min_q;
  assign w_rep_seg  = w_hold_seg && (r_rep_seg == REP_LAST);
  assign w_rep_min  = w_hold_min && (r_rep_min == REP_LAST);

  always_ff @(posedge clk) begin
    if (reset || bus.reset_timer) begin
      r_rep_seg <= '0;
      r_rep_min <= '0;
    end else begin
      r_rep_seg <= (w_hold_seg && !w_rep_seg) ? r_rep_seg + 1'b1 : '0;
      r_rep_min <= (w_hold_min && !w_rep_min) ? r_rep_min + 1'b1 : '0;
    end
  end
`else
  assign w_rep_seg = 1'b0;
  assign w_rep_min = 1'b0;
`endif

  assign w_seg_inc = w_set & ((bus.seg_demand & ~r_seg_q) | w_rep_seg);
  assign w_min_inc = w_set & ((bus.min_demand & ~r_min_q) | w_rep_min);

  always_comb begin
    w_su    = r_su;
    w_st    = r_st;
    w_mu    = r_mu;
    w_mt    = r_mt;
    w_presc = r_presc;
    w_done  = 1'b0;
    if (w_set) begin
      w_presc = '0;
      if (w_seg_inc) begin
        if (r_su == 4'd9) begin
          w_su = 4'd0;
          w_st = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
        end else begin
          w_su = r_su + 4'd1;
        end
      end
      if (w_min_inc) begin
        if (r_mu == 4'd9) begin
          w_mu = 4'd0;
          w_mt = (r_mt == 4'd9) ? 4'd0 : r_mt + 4'd1;
        end else begin
          w_mu = r_mu + 4'd1;
        end
      end
    end else if (w_cnt) begin
      w_presc = w_tick ? '0 : r_presc + 1'b1;
      // Borrow chain runs only while time remains; at 00:00 the tick is ignored.
      if (w_tick && !r_zero) begin
        w_done = w_at_one;
        if (r_su != 4'd0) begin
          w_su = r_su - 4'd1;
        end else begin
          w_su = 4'd9;
          if (r_st != 4'd0) begin
            w_st = r_st - 4'd1;
          end else begin
            w_st = 4'd5;
            if (r_mu != 4'd0) begin
              w_mu = r_mu - 4'd1;
            end else begin
              w_mu = 4'd9;
              w_mt = r_mt - 4'd1;
            end
          end
        end
      end
    end
    w_zero = (w_su == 4'd0) && (w_st == 4'd0) && (w_mu == 4'd0) && (w_mt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.reset_timer) begin
      r_su    <= 4'd0;
      r_st    <= 4'd0;
      r_mu    <= 4'd0;
      r_mt    <= 4'd0;
      r_presc <= '0;
      r_seg_q <= 1'b0;
      r_min_q <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_su    <= w_su;
      r_st    <= w_st;
      r_mu    <= w_mu;
      r_mt    <= w_mt;
      r_presc <= w_presc;
      r_seg_q <= bus.seg_demand;
      r_min_q <= bus.min_demand;
      r_zero  <= w_zero;
      r_done  <= w_done;
    end
  end

  assign bus.sec_units = r_su;
  assign bus.sec_tens  = r_st;
  assign bus.min_units = r_mu;
  assign bus.min_tens  = r_mt;
  assign bus.zero      = r_zero;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_timer_counter_bcd.sv
// Bench for timer_counter_bcd: table vectors, directed corner sequences and random stimulus
// checked every cycle against a total-seconds reference model.
module tb_timer_counter_bcd;
  localparam int T = 4;
  localparam int R = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  timer_counter_bcd_if bus();

  timer_counter_bcd #(.TICKS_PER_SEC(T), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time kept as plain minutes/seconds integers.
  int  m_min = 0, m_sec = 0, m_presc = 0, m_hold_s = 0, m_hold_m = 0;
  bit  m_pseg = 0, m_pmin = 0, m_done = 0;

  typedef struct {
    bit rst, en, fwd, rt, seg, mn;
    int exp_mm, exp_ss;
    bit exp_zero, exp_done;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int dut_mm();
    return int'(bus.min_tens) * 10 + int'(bus.min_units);
  endfunction

  function automatic int dut_ss();
    return int'(bus.sec_tens) * 10 + int'(bus.sec_units);
  endfunction

  task automatic model_step();
    int total;
    m_done = 0;
    if (reset || bus.reset_timer) begin
      m_min = 0; m_sec = 0; m_presc = 0; m_pseg = 0; m_pmin = 0;
      m_hold_s = 0; m_hold_m = 0;
    end else begin
      if (bus.enable_counter && bus.forward) begin
        m_presc = 0;
        if (bus.seg_demand && !m_pseg) m_sec = (m_sec + 1) % 60;
        if (bus.min_demand && !m_pmin) m_min = (m_min + 1) % 100;
`ifdef TIMER_AUTOREPEAT_EN
        if (bus.seg_demand && m_pseg) begin
          m_hold_s++;
          if (m_hold_s % R == 0) m_sec = (m_sec + 1) % 60;
        end else m_hold_s = 0;
        if (bus.min_demand && m_pmin) begin
          m_hold_m++;
          if (m_hold_m % R == 0) m_min = (m_min + 1) % 100;
        end else m_hold_m = 0;
`endif
      end else begin
        m_hold_s = 0; m_hold_m = 0;
        if (bus.enable_counter) begin
          if (m_presc == T - 1) begin
            m_presc = 0;
            total = m_min * 60 + m_sec;
            if (total > 0) begin
              total--;
              m_done = (total == 0);
              m_min = total / 60;
              m_sec = total % 60;
            end
          end else m_presc++;
        end
      end
      m_pseg = bus.seg_demand;
      m_pmin = bus.min_demand;
    end
  endtask

  task automatic cyc();
    logic [17:0] got, exp;
    @(posedge clk);
    model_step();
    #1;
    got = {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units, bus.zero, bus.done};
    exp = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
           1'(m_min == 0 && m_sec == 0), 1'(m_done)};
    chk("model", int'(got), int'(exp));
  endtask

  task automatic drive(input bit rst, input bit en, input bit fwd, input bit rt,
                       input bit seg, input bit mn);
    reset = rst;
    bus.enable_counter = en;
    bus.forward = fwd;
    bus.reset_timer = rt;
    bus.seg_demand = seg;
    bus.min_demand = mn;
  endtask

  task automatic pulses(input bit is_min, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_min) bus.min_demand = 1'b1; else bus.seg_demand = 1'b1;
      cyc();
      bus.min_demand = 1'b0; bus.seg_demand = 1'b0;
      cyc();
    end
  endtask

  task automatic clear_and_set(input int mm, input int ss);
    drive(0, 1, 1, 1, 0, 0); cyc();
    drive(0, 1, 1, 0, 0, 0);
    pulses(1, mm);
    pulses(0, ss);
  endtask

  task automatic chk_time(input string name, input int mm, input int ss);
    chk(name, dut_mm() * 100 + dut_ss(), mm * 100 + ss);
  endtask

  vec_t vecs[10];
  int   dcount;

  initial begin
    drive(1, 0, 0, 0, 1, 1);
    vecs[0] = '{1,0,0,0,1,1, 0,0, 1,0};
    vecs[1] = '{1,0,0,0,1,1, 0,0, 1,0};
    vecs[2] = '{0,0,0,0,1,1, 0,0, 1,0};
    vecs[3] = '{0,1,1,0,1,1, 0,0, 1,0};
    vecs[4] = '{0,1,1,0,0,0, 0,0, 1,0};
    vecs[5] = '{0,1,1,0,1,0, 0,1, 0,0};
    vecs[6] = '{0,1,1,0,1,1, 1,1, 0,0};
    vecs[7] = '{0,1,1,0,0,0, 1,1, 0,0};
    vecs[8] = '{0,1,1,1,0,0, 0,0, 1,0};
    vecs[9] = '{0,1,0,0,0,0, 0,0, 1,0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].fwd, vecs[i].rt, vecs[i].seg, vecs[i].mn);
      cyc();
      chk($sformatf("vec%0d_time", i), dut_mm() * 100 + dut_ss(),
          vecs[i].exp_mm * 100 + vecs[i].exp_ss);
      chk($sformatf("vec%0d_zd", i), int'({bus.zero, bus.done}),
          int'({vecs[i].exp_zero, vecs[i].exp_done}));
    end

    // Set mode accumulation and wraps
    clear_and_set(3, 61);
    chk_time("set_03_01", 3, 1);
    clear_and_set(100, 0);
    chk_time("min_wrap_100", 0, 0);

    // Countdown from 01:00 to 00:00 with one done pulse
    clear_and_set(1, 0);
    bus.forward = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk_time("cd_before_tick", 1, 0);
    cyc();
    chk_time("cd_first_step", 0, 59);
    for (int i = 4; i < 239; i++) cyc();
    chk_time("cd_at_0001", 0, 1);
    chk("cd_no_early_done", int'(bus.done), 0);
    cyc();
    chk_time("cd_at_0000", 0, 0);
    chk("cd_done_zero", int'({bus.zero, bus.done}), 3);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      dcount += int'(bus.done);
    end
    chk("cd_no_more_done", dcount, 0);

    // Pause mid-second and resume without losing the partial second
    clear_and_set(10, 0);
    bus.forward = 1'b0;
    cyc(); cyc();
    bus.enable_counter = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk_time("hold_frozen", 10, 0);
    bus.enable_counter = 1'b1;
    cyc();
    chk_time("resume_1", 10, 0);
    cyc();
    chk_time("resume_2", 9, 59);

    // reset_timer mid-countdown
    clear_and_set(5, 30);
    bus.forward = 1'b0;
    cyc(); cyc();
    bus.reset_timer = 1'b1;
    cyc();
    bus.reset_timer = 1'b0;
    chk_time("rt_clear", 0, 0);
    chk("rt_no_done", int'({bus.zero, bus.done}), 2);

    // Both wraps in the same cycle
    clear_and_set(99, 59);
    chk_time("load_9959", 99, 59);
    bus.seg_demand = 1'b1; bus.min_demand = 1'b1;
    cyc();
    bus.seg_demand = 1'b0; bus.min_demand = 1'b0;
    chk_time("dual_wrap", 0, 0);
    chk("dual_wrap_done", int'(bus.done), 0);

    // Held seg_demand
    clear_and_set(0, 0);
    bus.seg_demand = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    bus.seg_demand = 1'b0;
`ifdef TIMER_AUTOREPEAT_EN
    chk_time("held_seg", 0, 4);
`else
    chk_time("held_seg", 0, 1);
`endif
    cyc();

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      reset              = ($urandom_range(0, 299) == 0);
      bus.reset_timer    = ($urandom_range(0, 149) == 0);
      bus.enable_counter = ($urandom_range(0, 7) != 0);
      bus.forward        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) bus.seg_demand = ~bus.seg_demand;
      if ($urandom_range(0, 3) == 0) bus.min_demand = ~bus.min_demand;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
